osl_tx_arb: RTL and testbench

OSL_TX_ARB -- requirements
Module: osl_tx_arb

---
 rtl/osl_tx_arb_pkg.sv | 25 ++
 rtl/osl_rr_sel.sv | 28 ++
 rtl/osl_tx_arb.sv | 98 +++++++++
 tb/tb_osl_tx_arb.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osl_tx_arb_pkg.sv
// Shared link-arbiter definitions: word width, arbiter state encodings, default port count.
`ifndef OSL_H
`define OSL_H
`ifndef WORDSZ
`define WORDSZ 8
`endif
`define ARB_NREQ 4
`define ARB_IDLE 2'd0
`define ARB_WR   2'd1
`define ARB_HOLD 2'd2
`define ARB_WAIT 2'd3
`endif

package osl_tx_arb_pkg;

  localparam int unsigned ARB_NREQ_DFLT = `ARB_NREQ;

  typedef enum logic [1:0] {
    ARB_IDLE = `ARB_IDLE,
    ARB_WR   = `ARB_WR,
    ARB_HOLD = `ARB_HOLD,
    ARB_WAIT = `ARB_WAIT
  } arb_state_e;

endpackage

// File: rtl/osl_rr_sel.sv
// Combinational round-robin selector: first set request after the last grant, wrapping.
module osl_rr_sel #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int unsigned IW = $clog2(NREQ);

  // Scan from last+1 around to last; the first hit wins.
  always_comb begin
    int unsigned c;
    valid = 1'b0;
    idx   = last;
    c     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      c = (32'(last) + k) % NREQ;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = c[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/osl_tx_arb.sv
// Link transmit arbiter: per-requester one-word slots issued round-robin to the link host port.
`ifndef WORDSZ
`define WORDSZ 8
`endif

module osl_tx_arb
  import osl_tx_arb_pkg::*;
#(
  parameter int unsigned NREQ = ARB_NREQ_DFLT
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic [NREQ-1:0]          req_en,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*`WORDSZ-1:0]  req_din,
  output logic [NREQ-1:0]          req_dir,
  output logic                     host_wr,
  output logic [`WORDSZ-1:0]       host_din,
  input  logic                     host_dir,
  output logic [1:0]               grant_id,
  output logic                     busy,
  output logic [NREQ-1:0]          err_ovf,
  input  logic                     err_clr
);

  arb_state_e         state, state_nxt;
  logic [`WORDSZ-1:0] slot [NREQ];
  logic [NREQ-1:0]    full;
  logic               sel_valid;
  logic [1:0]         sel_idx;
  logic               issue;

  osl_rr_sel #(.NREQ(NREQ)) u_rr_sel (
    .req   (full & req_en),
    .last  (grant_id),
    .valid (sel_valid),
    .idx   (sel_idx)
  );

  assign req_dir = ~full;
  assign host_wr = (state == ARB_WR);
  assign busy    = (state != ARB_IDLE);

  // Next-state logic; issue marks the IDLE->WR edge where the winner is latched.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      ARB_IDLE: if (host_dir && sel_valid) begin
        state_nxt = ARB_WR;
        issue     = 1'b1;
      end
      ARB_WR:   state_nxt = ARB_HOLD;
      ARB_HOLD: state_nxt = ARB_WAIT;
      ARB_WAIT: if (host_dir) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= ARB_IDLE;
    else         state <= state_nxt;
  end

  // Latch winner and its word at issue; host_din then holds it until the next issue.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      grant_id <= 2'(NREQ-1);
      host_din <= '0;
    end else if (issue) begin
      grant_id <= sel_idx;
      host_din <= slot[sel_idx];
    end
  end

  // Holding slots: load when empty, flag overflow when full, empty at end of WR.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      full    <= '0;
      err_ovf <= '0;
      for (int unsigned i = 0; i < NREQ; i++) slot[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_wr[i] && !full[i]) begin
          slot[i] <= req_din[i*`WORDSZ +: `WORDSZ];
          full[i] <= 1'b1;
        end else if ((state == ARB_WR) && (grant_id == 2'(i))) begin
          full[i] <= 1'b0;
        end
        // A new overflow takes priority over a same-cycle clear.
        if (req_wr[i] && full[i]) err_ovf[i] <= 1'b1;
        else if (err_clr)         err_ovf[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_osl_tx_arb.sv
// Directed self-checking bench for osl_tx_arb with a simple link-host model.
`ifndef WORDSZ
`define WORDSZ 8
`endif

module tb_osl_tx_arb;

  localparam int W = `WORDSZ;

  logic           clk;
  logic           resetb;
  logic [3:0]     req_en;
  logic [3:0]     req_wr;
  logic [4*W-1:0] req_din;
  logic [3:0]     req_dir;
  logic           host_wr;
  logic [W-1:0]   host_din;
  logic           host_dir;
  logic [1:0]     grant_id;
  logic           busy;
  logic [3:0]     err_ovf;
  logic           err_clr;

  typedef struct {
    int unsigned  cyc;
    logic [W-1:0] d;
    logic [1:0]   g;
  } iss_t;

  iss_t        q[$];
  int unsigned cyc;
  logic        wr_prev;
  logic        host_stall;
  int          lowcnt;
  int          n_chk;
  int          n_pass;

  osl_tx_arb #(.NREQ(4)) dut (
    .clk      (clk),
    .resetb   (resetb),
    .req_en   (req_en),
    .req_wr   (req_wr),
    .req_din  (req_din),
    .req_dir  (req_dir),
    .host_wr  (host_wr),
    .host_din (host_din),
    .host_dir (host_dir),
    .grant_id (grant_id),
    .busy     (busy),
    .err_ovf  (err_ovf),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin @(posedge clk); cyc++; end
  end

  // Record every host write at mid-cycle.
  initial begin
    wr_prev = 1'b0;
    forever begin
      @(negedge clk);
      wr_prev = host_wr;
      if (host_wr) q.push_back('{cyc, host_din, grant_id});
    end
  end

  // Host: drops host_dir the cycle after a write, raises it 3 cycles after the write.
  initial begin
    host_dir = 1'b1;
    lowcnt   = 0;
    forever begin
      @(posedge clk); #1;
      if (wr_prev) begin
        host_dir = 1'b0;
        lowcnt   = 1;
      end else if (!host_dir) begin
        lowcnt++;
        if (lowcnt >= 3 && !host_stall) host_dir = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] w);
    req_din[i*W +: W] = w;
  endtask

  task automatic wait_n(input int n, input int budget);
    for (int k = 0; k < budget && q.size() < n; k++) tick(1);
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && busy; k++) tick(1);
  endtask

  task automatic do_reset();
    resetb     = 1'b0;
    req_wr     = '0;
    err_clr    = 1'b0;
    host_stall = 1'b0;
    req_en     = 4'b1111;
    tick(2);
    resetb = 1'b1;
    tick(3);
    q.delete();
  endtask

  task automatic test_reset();
    tick(1);
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (req_dir !== 4'b1111) $display("FAIL rst_req_dir: got %b want 1111", req_dir); else n_pass++;
    n_chk++; if (host_wr !== 1'b0) $display("FAIL rst_host_wr: got %b want 0", host_wr); else n_pass++;
    n_chk++; if (host_din !== W'(0)) $display("FAIL rst_host_din: got %h want 0", host_din); else n_pass++;
    n_chk++; if (err_ovf !== 4'b0000) $display("FAIL rst_err_ovf: got %b want 0000", err_ovf); else n_pass++;
    n_chk++; if (grant_id !== 2'd3) $display("FAIL rst_grant_id: got %0d want 3", grant_id); else n_pass++;
    resetb = 1'b1;
    tick(2);
  endtask

  task automatic test_single();
    set_word(2, W'(8'h5A));
    req_wr = 4'b0100;
    tick(1);
    req_wr = '0;
    n_chk++; if (req_dir !== 4'b1011) $display("FAIL single_dir_full: got %b want 1011", req_dir); else n_pass++;
    n_chk++; if (host_wr !== 1'b0) $display("FAIL single_no_early_wr: got %b want 0", host_wr); else n_pass++;
    tick(1);
    n_chk++; if (host_wr !== 1'b1) $display("FAIL single_host_wr: got %b want 1", host_wr); else n_pass++;
    n_chk++; if (host_din !== W'(8'h5A)) $display("FAIL single_host_din: got %h want 5a", host_din); else n_pass++;
    n_chk++; if (grant_id !== 2'd2) $display("FAIL single_grant: got %0d want 2", grant_id); else n_pass++;
    tick(1);
    n_chk++; if (host_wr !== 1'b0) $display("FAIL single_wr_one_cycle: got %b want 0", host_wr); else n_pass++;
    n_chk++; if (req_dir !== 4'b1111) $display("FAIL single_dir_free: got %b want 1111", req_dir); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL single_busy_hold: got %b want 1", busy); else n_pass++;
    wait_idle(20);
    n_chk++; if (busy !== 1'b0) $display("FAIL single_idle: got busy %b want 0", busy); else n_pass++;
    n_chk++; if (host_din !== W'(8'h5A)) $display("FAIL single_din_held: got %h want 5a", host_din); else n_pass++;
    n_chk++; if (q.size() != 1) $display("FAIL single_count: got %0d want 1", q.size()); else n_pass++;
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < 4; i++) set_word(i, W'(8'h10 + i));
    req_wr = 4'b1111;
    tick(1);
    req_wr = '0;
    wait_n(4, 40);
    n_chk++; if (q.size() != 4) $display("FAIL four_count: got %0d want 4", q.size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      if (q.size() > k) begin
        n_chk++; if (q[k].d !== W'(8'h10 + k)) $display("FAIL four_data%0d: got %h want %h", k, q[k].d, 8'h10 + k); else n_pass++;
        n_chk++; if (q[k].g !== 2'(k)) $display("FAIL four_order%0d: got %0d want %0d", k, q[k].g, k); else n_pass++;
      end
      if (k > 0 && q.size() > k) begin
        n_chk++; if (q[k].cyc - q[k-1].cyc != 5) $display("FAIL four_spacing%0d: got %0d want 5", k, q[k].cyc - q[k-1].cyc); else n_pass++;
      end
    end
    wait_idle(20);
  endtask

  task automatic test_round_robin();
    do_reset();
    set_word(1, W'(8'h21));
    req_wr = 4'b0010;
    tick(1);
    req_wr = '0;
    wait_n(1, 10);
    wait_idle(20);
    n_chk++; if (grant_id !== 2'd1) $display("FAIL rr_grant_setup: got %0d want 1", grant_id); else n_pass++;
    q.delete();
    set_word(0, W'(8'h30));
    set_word(3, W'(8'h33));
    req_wr = 4'b1001;
    tick(1);
    req_wr = '0;
    wait_n(2, 30);
    n_chk++; if (q.size() != 2) $display("FAIL rr_count: got %0d want 2", q.size()); else n_pass++;
    if (q.size() == 2) begin
      n_chk++; if (q[0].g !== 2'd3 || q[0].d !== W'(8'h33)) $display("FAIL rr_first: got id %0d data %h want id 3 data 33", q[0].g, q[0].d); else n_pass++;
      n_chk++; if (q[1].g !== 2'd0 || q[1].d !== W'(8'h30)) $display("FAIL rr_second: got id %0d data %h want id 0 data 30", q[1].g, q[1].d); else n_pass++;
    end
    wait_idle(20);
  endtask

  task automatic test_overflow();
    do_reset();
    req_en = 4'b1101;
    set_word(1, W'(8'h41));
    req_wr = 4'b0010;
    tick(1);
    set_word(1, W'(8'h42));
    tick(1);
    req_wr = '0;
    n_chk++; if (err_ovf !== 4'b0010) $display("FAIL ovf_set: got %b want 0010", err_ovf); else n_pass++;
    n_chk++; if (req_dir !== 4'b1101) $display("FAIL ovf_dir: got %b want 1101", req_dir); else n_pass++;
    tick(3);
    n_chk++; if (err_ovf !== 4'b0010) $display("FAIL ovf_sticky: got %b want 0010", err_ovf); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL ovf_disabled_idle: got %b want 0", busy); else n_pass++;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    n_chk++; if (err_ovf !== 4'b0000) $display("FAIL ovf_clear: got %b want 0000", err_ovf); else n_pass++;
    err_clr = 1'b1;
    set_word(1, W'(8'h43));
    req_wr = 4'b0010;
    tick(1);
    err_clr = 1'b0;
    req_wr = '0;
    n_chk++; if (err_ovf !== 4'b0010) $display("FAIL ovf_beats_clear: got %b want 0010", err_ovf); else n_pass++;
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    req_en = 4'b1111;
    wait_n(1, 10);
    n_chk++; if (q.size() != 1) $display("FAIL ovf_issue_count: got %0d want 1", q.size()); else n_pass++;
    if (q.size() == 1) begin
      n_chk++; if (q[0].d !== W'(8'h41)) $display("FAIL ovf_kept_first: got %h want 41", q[0].d); else n_pass++;
    end
    wait_idle(20);
  endtask

  task automatic test_write_during_wr();
    do_reset();
    set_word(0, W'(8'hAA));
    req_wr = 4'b0001;
    tick(1);
    req_wr = '0;
    tick(1);
    n_chk++; if (host_wr !== 1'b1) $display("FAIL wrov_in_wr: got %b want 1", host_wr); else n_pass++;
    set_word(0, W'(8'hBB));
    req_wr = 4'b0001;
    tick(1);
    n_chk++; if (err_ovf !== 4'b0001) $display("FAIL wrov_ovf: got %b want 0001", err_ovf); else n_pass++;
    n_chk++; if (req_dir !== 4'b1111) $display("FAIL wrov_dir_free: got %b want 1111", req_dir); else n_pass++;
    set_word(0, W'(8'hCC));
    tick(1);
    req_wr = '0;
    n_chk++; if (req_dir !== 4'b1110) $display("FAIL wrov_reload: got %b want 1110", req_dir); else n_pass++;
    wait_n(2, 30);
    n_chk++; if (q.size() != 2) $display("FAIL wrov_count: got %0d want 2", q.size()); else n_pass++;
    if (q.size() == 2) begin
      n_chk++; if (q[0].d !== W'(8'hAA)) $display("FAIL wrov_first: got %h want aa", q[0].d); else n_pass++;
      n_chk++; if (q[1].d !== W'(8'hCC)) $display("FAIL wrov_second: got %h want cc", q[1].d); else n_pass++;
    end
    wait_idle(20);
  endtask

  task automatic test_enable();
    do_reset();
    req_en = 4'b1110;
    set_word(0, W'(8'h77));
    req_wr = 4'b0001;
    tick(1);
    req_wr = '0;
    tick(20);
    n_chk++; if (q.size() != 0) $display("FAIL en_blocked: got %0d writes want 0", q.size()); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL en_idle: got %b want 0", busy); else n_pass++;
    n_chk++; if (req_dir !== 4'b1110) $display("FAIL en_slot_kept: got %b want 1110", req_dir); else n_pass++;
    req_en = 4'b1111;
    wait_n(1, 10);
    n_chk++; if (q.size() != 1) $display("FAIL en_issue_count: got %0d want 1", q.size()); else n_pass++;
    if (q.size() == 1) begin
      n_chk++; if (q[0].d !== W'(8'h77) || q[0].g !== 2'd0) $display("FAIL en_issue: got id %0d data %h want id 0 data 77", q[0].g, q[0].d); else n_pass++;
    end
    wait_idle(20);
  endtask

  task automatic test_reset_mid();
    do_reset();
    host_stall = 1'b1;
    set_word(0, W'(8'h55));
    set_word(1, W'(8'h66));
    req_wr = 4'b0011;
    tick(1);
    req_wr = '0;
    tick(1);
    n_chk++; if (host_wr !== 1'b1) $display("FAIL mid_in_wr: got %b want 1", host_wr); else n_pass++;
    tick(2);
    n_chk++; if (busy !== 1'b1 || host_wr !== 1'b0) $display("FAIL mid_in_wait: got busy %b wr %b want 1 0", busy, host_wr); else n_pass++;
    resetb = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (req_dir !== 4'b1111) $display("FAIL mid_rst_dir: got %b want 1111", req_dir); else n_pass++;
    n_chk++; if (host_din !== W'(0) || grant_id !== 2'd3) $display("FAIL mid_rst_regs: got din %h id %0d want 0 3", host_din, grant_id); else n_pass++;
    tick(1);
    resetb     = 1'b1;
    host_stall = 1'b0;
    q.delete();
    tick(12);
    n_chk++; if (q.size() != 0) $display("FAIL mid_no_issue: got %0d writes want 0", q.size()); else n_pass++;
    n_chk++; if (busy !== 1'b0 || req_dir !== 4'b1111) $display("FAIL mid_after: got busy %b dir %b want 0 1111", busy, req_dir); else n_pass++;
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    resetb     = 1'b0;
    req_en     = 4'b1111;
    req_wr     = '0;
    req_din    = '0;
    err_clr    = 1'b0;
    host_stall = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_round_robin();
    test_overflow();
    test_write_during_wr();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
